// File: rtl/dmac_dispatch_1to8.sv
// Registered 1-to-8 write dispatcher: one word goes to one of eight valid/ack targets.
// Optional SEND timeout with err pulse when DMAC_DISPATCH_TIMEOUT_EN is defined.
module dmac_dispatch_1to8 #(
    parameter int DATA_W = 32,
    parameter int TO_CYC = 16
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req,
    input  logic [2:0]        sel,
    input  logic [DATA_W-1:0] d_in,
    input  logic [7:0]        ack,
    output logic [DATA_W-1:0] a,
    output logic [DATA_W-1:0] b,
    output logic [DATA_W-1:0] c,
    output logic [DATA_W-1:0] d,
    output logic [DATA_W-1:0] e,
    output logic [DATA_W-1:0] f,
    output logic [DATA_W-1:0] g,
    output logic [DATA_W-1:0] h,
    output logic [7:0]        vld,
    output logic              busy,
    output logic              done,
    output logic              err
);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t            state;
    state_t            state_nxt;
    logic [2:0]        sel_q;
    logic [DATA_W-1:0] port_q [8];
    logic [7:0]        vld_q;
    logic              done_q;
    logic              err_q;
    logic              accept;
    logic              hit;
    logic              tmo;
    logic              done_nxt;
    logic              err_nxt;

    if (TO_CYC < 1 || TO_CYC > 255) begin : g_to_range
        $error("TO_CYC must be within 1..255");
    end

    assign hit = ack[sel_q];

`ifdef DMAC_DISPATCH_TIMEOUT_EN
    localparam logic [7:0] TO_LAST = 8'(TO_CYC - 1);

    logic [7:0] cnt;

    assign tmo = (cnt == TO_LAST);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (accept) begin
            cnt <= '0;
        end else if (state == SEND && !hit) begin
            cnt <= cnt + 8'd1;
        end
    end
`else
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ack outranks timeout when both land on the same edge
    always_comb begin
        state_nxt = state;
        accept    = 1'b0;
        done_nxt  = 1'b0;
        err_nxt   = 1'b0;
        unique case (state)
            IDLE: begin
                if (req) begin
                    accept    = 1'b1;
                    state_nxt = SEND;
                end
            end
            SEND: begin
                if (hit) begin
                    done_nxt  = 1'b1;
                    state_nxt = IDLE;
                end else if (tmo) begin
                    err_nxt   = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sel_q  <= '0;
            vld_q  <= '0;
            done_q <= 1'b0;
            err_q  <= 1'b0;
            for (int i = 0; i < 8; i++) begin
                port_q[i] <= '0;
            end
        end else begin
            done_q <= done_nxt;
            err_q  <= err_nxt;
            if (accept) begin
                sel_q <= sel;
                vld_q <= 8'd1 << sel;
                for (int i = 0; i < 8; i++) begin
                    port_q[i] <= (sel == 3'(i)) ? d_in : '0;
                end
            end else if (state_nxt == IDLE) begin
                vld_q <= '0;
                for (int i = 0; i < 8; i++) begin
                    port_q[i] <= '0;
                end
            end
        end
    end

    assign a    = port_q[0];
    assign b    = port_q[1];
    assign c    = port_q[2];
    assign d    = port_q[3];
    assign e    = port_q[4];
    assign f    = port_q[5];
    assign g    = port_q[6];
    assign h    = port_q[7];
    assign vld  = vld_q;
    assign busy = (state == SEND);
    assign done = done_q;
    assign err  = err_q;

endmodule

// File: tb/tb_dmac_dispatch_1to8.sv
// Directed bench for dmac_dispatch_1to8 (TO_CYC=4).
// Timeout scenario follows DMAC_DISPATCH_TIMEOUT_EN.
module tb_dmac_dispatch_1to8;

    logic        clk;
    logic        reset;
    logic        req;
    logic [2:0]  sel;
    logic [31:0] d_in;
    logic [7:0]  ack;
    logic [31:0] a, b, c, d, e, f, g, h;
    logic [7:0]  vld;
    logic        busy;
    logic        done;
    logic        err;

    logic [31:0] ports [8];
    logic [31:0] port_or;
    logic [10:0] st;
    logic [31:0] exp_p;
    int          vecs;
    int          miscompares;

    dmac_dispatch_1to8 #(
        .DATA_W(32),
        .TO_CYC(4)
    ) dut (
        .clk  (clk),
        .reset(reset),
        .req  (req),
        .sel  (sel),
        .d_in (d_in),
        .ack  (ack),
        .a    (a),
        .b    (b),
        .c    (c),
        .d    (d),
        .e    (e),
        .f    (f),
        .g    (g),
        .h    (h),
        .vld  (vld),
        .busy (busy),
        .done (done),
        .err  (err)
    );

    assign ports[0] = a;
    assign ports[1] = b;
    assign ports[2] = c;
    assign ports[3] = d;
    assign ports[4] = e;
    assign ports[5] = f;
    assign ports[6] = g;
    assign ports[7] = h;
    assign port_or  = a | b | c | d | e | f | g | h;
    assign st       = {vld, busy, done, err};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic test_reset();
        reset = 1'b1;
        req   = 1'b0;
        sel   = 3'd0;
        d_in  = '0;
        ack   = '0;
        repeat (2) @(negedge clk);
        vecs++;
        if (st !== 11'h0 || port_or !== 32'h0) begin
            miscompares++;
            $display("FAIL rst_hold: st=%h ports=%h exp st=0 ports=0", st, port_or);
        end
        reset = 1'b0;
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            vecs++;
            if (st !== 11'h0 || port_or !== 32'h0) begin
                miscompares++;
                $display("FAIL rst_idle%0d: st=%h ports=%h exp 0", k, st, port_or);
            end
        end
    endtask

    task automatic test_single();
        @(negedge clk);
        req  = 1'b1;
        sel  = 3'd3;
        d_in = 32'hDEADBEEF;
        for (int k = 1; k <= 2; k++) begin
            @(negedge clk);
            req = 1'b0;
            vecs++;
            if (st !== {8'h08, 1'b1, 1'b0, 1'b0}) begin
                miscompares++;
                $display("FAIL single_send%0d: st=%h exp %h", k, st, {8'h08, 3'b100});
            end
            for (int i = 0; i < 8; i++) begin
                exp_p = (i == 3) ? 32'hDEADBEEF : 32'h0;
                vecs++;
                if (ports[i] !== exp_p) begin
                    miscompares++;
                    $display("FAIL single_port%0d: got %h exp %h", i, ports[i], exp_p);
                end
            end
            if (k == 2) ack = 8'h08;
        end
        @(negedge clk);
        ack = 8'h00;
        vecs++;
        if (st !== {8'h00, 3'b010} || port_or !== 32'h0) begin
            miscompares++;
            $display("FAIL single_done: st=%h ports=%h exp st=002 ports=0", st, port_or);
        end
        @(negedge clk);
        vecs++;
        if (st !== 11'h0) begin
            miscompares++;
            $display("FAIL single_after: st=%h exp 000", st);
        end
    endtask

    task automatic test_back_to_back();
        for (int s = 0; s < 8; s++) begin
            @(negedge clk);
            if (s > 0) begin
                vecs++;
                if (st !== {8'h00, 3'b010}) begin
                    miscompares++;
                    $display("FAIL sweep_done%0d: st=%h exp 002", s - 1, st);
                end
            end
            req  = 1'b1;
            sel  = 3'(s);
            d_in = 32'h1000_0000 + 32'(s);
            ack  = 8'd1 << s;
            @(negedge clk);
            req = 1'b0;
            vecs++;
            if (st !== {8'd1 << s, 3'b100}) begin
                miscompares++;
                $display("FAIL sweep_send%0d: st=%h exp %h", s, st, {8'd1 << s, 3'b100});
            end
            for (int i = 0; i < 8; i++) begin
                exp_p = (i == s) ? 32'h1000_0000 + 32'(s) : 32'h0;
                vecs++;
                if (ports[i] !== exp_p) begin
                    miscompares++;
                    $display("FAIL sweep%0d_port%0d: got %h exp %h", s, i, ports[i], exp_p);
                end
            end
        end
        @(negedge clk);
        ack = 8'h00;
        vecs++;
        if (st !== {8'h00, 3'b010}) begin
            miscompares++;
            $display("FAIL sweep_done7: st=%h exp 002", st);
        end
        @(negedge clk);
        vecs++;
        if (st !== 11'h0 || port_or !== 32'h0) begin
            miscompares++;
            $display("FAIL sweep_idle: st=%h ports=%h exp 0", st, port_or);
        end
    endtask

    task automatic test_timeout();
        @(negedge clk);
        req  = 1'b1;
        sel  = 3'd5;
        d_in = 32'hCAFE_0005;
        ack  = 8'h00;
`ifdef DMAC_DISPATCH_TIMEOUT_EN
        for (int k = 1; k <= 4; k++) begin
`else
        for (int k = 1; k <= 20; k++) begin
`endif
            @(negedge clk);
            req = 1'b0;
            vecs++;
            if (st !== {8'h20, 3'b100} || f !== 32'hCAFE_0005) begin
                miscompares++;
                $display("FAIL to_send%0d: st=%h f=%h exp st=%h f=cafe0005", k, st, f, {8'h20, 3'b100});
            end
            ack = k[0] ? 8'h84 : 8'h00;
        end
`ifdef DMAC_DISPATCH_TIMEOUT_EN
        @(negedge clk);
        ack = 8'h84;
        vecs++;
        if (st !== {8'h00, 3'b001} || port_or !== 32'h0) begin
            miscompares++;
            $display("FAIL to_err: st=%h ports=%h exp st=001 ports=0", st, port_or);
        end
        @(negedge clk);
        ack = 8'h00;
        vecs++;
        if (st !== 11'h0) begin
            miscompares++;
            $display("FAIL to_after: st=%h exp 000", st);
        end
`else
        reset = 1'b1;
        #1;
        ack = 8'h00;
        vecs++;
        if (st !== 11'h0 || port_or !== 32'h0) begin
            miscompares++;
            $display("FAIL noto_rst: st=%h ports=%h exp 0", st, port_or);
        end
        @(negedge clk);
        reset = 1'b0;
`endif
    endtask

    task automatic test_ack_priority();
        @(negedge clk);
        req  = 1'b1;
        sel  = 3'd6;
        d_in = 32'h0BAD_F00D;
        ack  = 8'h00;
        for (int k = 1; k <= 4; k++) begin
            @(negedge clk);
            req = 1'b0;
            vecs++;
            if (st !== {8'h40, 3'b100} || g !== 32'h0BAD_F00D) begin
                miscompares++;
                $display("FAIL prio_send%0d: st=%h g=%h exp st=%h", k, st, g, {8'h40, 3'b100});
            end
            if (k == 4) ack = 8'h40;
        end
        @(negedge clk);
        ack = 8'h00;
        vecs++;
        if (st !== {8'h00, 3'b010}) begin
            miscompares++;
            $display("FAIL prio_done: st=%h exp 002", st);
        end
        @(negedge clk);
        vecs++;
        if (st !== 11'h0) begin
            miscompares++;
            $display("FAIL prio_after: st=%h exp 000", st);
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        req  = 1'b1;
        sel  = 3'd1;
        d_in = 32'h1111_2222;
        ack  = 8'h00;
        @(negedge clk);
        req = 1'b0;
        vecs++;
        if (st !== {8'h02, 3'b100} || b !== 32'h1111_2222) begin
            miscompares++;
            $display("FAIL mid_send: st=%h b=%h exp st=%h", st, b, {8'h02, 3'b100});
        end
        @(negedge clk);
        reset = 1'b1;
        #1;
        vecs++;
        if (st !== 11'h0 || port_or !== 32'h0) begin
            miscompares++;
            $display("FAIL mid_async: st=%h ports=%h exp 0", st, port_or);
        end
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        vecs++;
        if (st !== 11'h0) begin
            miscompares++;
            $display("FAIL mid_nopulse: st=%h exp 000", st);
        end
        req  = 1'b1;
        sel  = 3'd2;
        d_in = 32'h3333_4444;
        ack  = 8'h04;
        @(negedge clk);
        req = 1'b0;
        vecs++;
        if (st !== {8'h04, 3'b100} || c !== 32'h3333_4444) begin
            miscompares++;
            $display("FAIL mid_resend: st=%h c=%h exp st=%h", st, c, {8'h04, 3'b100});
        end
        @(negedge clk);
        ack = 8'h00;
        vecs++;
        if (st !== {8'h00, 3'b010}) begin
            miscompares++;
            $display("FAIL mid_done: st=%h exp 002", st);
        end
    endtask

    initial begin
        vecs        = 0;
        miscompares = 0;
        test_reset();
        test_single();
        test_back_to_back();
        test_timeout();
        test_ack_priority();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", vecs, miscompares);
        $finish;
    end

endmodule
